mux8_pingpong_feed: RTL and testbench

//  Two-bank (ping-pong) 8-bit buffer that sits directly upstream of mux8_2x1.

---
 rtl/mux8_pingpong_feed.sv | 90 +++++++++
 tb/tb_mux8_pingpong_feed.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mux8_pingpong_feed.sv
// ============================================================================
//  Module   : mux8_pingpong_feed
//  Purpose  : Two-bank ping-pong byte buffer that feeds a mux8_2x1; the mux
//             output (sel ? bank_a : bank_b) is always the oldest unread byte.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux8_pingpong_feed #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] bank_a,
    output logic [WIDTH-1:0] bank_b,
    output logic             sel,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic c_PTR_A = 1'b1;
    localparam logic c_PTR_B = 1'b0;

    state_t           state_q, state_d;
    logic             wr_ptr_q;
    logic             sel_q;
    logic [WIDTH-1:0] bank_a_q;
    logic [WIDTH-1:0] bank_b_q;

    logic             w_wr_fire;
    logic             w_rd_fire;

    // Handshake flags decode only registered state (plus rst for wr_ready).
    assign wr_ready  = !rst && (state_q != ST_FULL);
    assign rd_valid  = (state_q != ST_EMPTY);
    assign w_wr_fire = wr_valid && wr_ready;
    assign w_rd_fire = rd_valid && rd_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (w_wr_fire)                state_d = ST_ONE;
            ST_ONE: begin
                if (w_wr_fire && !w_rd_fire)        state_d = ST_FULL;
                else if (!w_wr_fire && w_rd_fire)   state_d = ST_EMPTY;
            end
            ST_FULL:  if (w_rd_fire)                state_d = ST_ONE;
            default:                                state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= c_PTR_A;
            sel_q    <= c_PTR_A;
            bank_a_q <= '0;
            bank_b_q <= '0;
        end else begin
            state_q <= state_d;
            if (w_wr_fire) begin
                if (wr_ptr_q == c_PTR_A) bank_a_q <= wr_data;
                else                     bank_b_q <= wr_data;
                wr_ptr_q <= ~wr_ptr_q;
            end
            // Consumed bank keeps its stale value; only the read pointer moves.
            if (w_rd_fire) begin
                sel_q <= ~sel_q;
            end
        end
    end

    assign bank_a = bank_a_q;
    assign bank_b = bank_b_q;
    assign sel    = sel_q;
    assign count  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mux8_pingpong_feed.sv
// ============================================================================
//  Module   : tb_mux8_pingpong_feed
//  Purpose  : Directed-vector bench with a reference FIFO checking the byte
//             order presented at the downstream mux output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux8_pingpong_feed;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] bank_a;
    logic [WIDTH-1:0] bank_b;
    logic             sel;
    logic [1:0]       count;

    int checks   = 0;
    int failures = 0;
    logic [WIDTH-1:0] exp_q[$];

    mux8_pingpong_feed #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .bank_a   (bank_a),
        .bank_b   (bank_b),
        .sel      (sel),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [WIDTH-1:0] mux_out = sel ? bank_a : bank_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted read is compared against the reference FIFO.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got 0x%0h expected none", mux_out);
            end else begin
                chk("sb_byte", {24'd0, mux_out}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write1(input logic [WIDTH-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        exp_q.push_back(d);
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

        // 1. reset
        step(); step();
        @(negedge clk);
        chk("rst_count",    count,    0);
        chk("rst_sel",      sel,      1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_bank_a",   bank_a,   0);
        chk("rst_bank_b",   bank_b,   0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rel_wr_ready", wr_ready, 1);
        step();

        // 2. fill with A5, 3C
        write1(8'hA5);
        write1(8'h3C);
        @(negedge clk);
        chk("t2_bank_a",   bank_a,   8'hA5);
        chk("t2_bank_b",   bank_b,   8'h3C);
        chk("t2_count",    count,    2);
        chk("t2_wr_ready", wr_ready, 0);
        chk("t2_sel",      sel,      1);
        chk("t2_mux",      mux_out,  8'hA5);

        // 3. drain
        step();
        rd_ready = 1'b1;
        step();
        @(negedge clk);
        chk("t3_sel1",   sel,     0);
        chk("t3_mux1",   mux_out, 8'h3C);
        chk("t3_count1", count,   1);
        step();
        rd_ready = 1'b0;
        @(negedge clk);
        chk("t3_sel2",     sel,      1);
        chk("t3_count2",   count,    0);
        chk("t3_rd_valid", rd_valid, 0);
        chk("t3_bank_a",   bank_a,   8'hA5);
        chk("t3_bank_b",   bank_b,   8'h3C);

        // EMPTY: rd_ready ignored
        step();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        @(negedge clk);
        chk("empty_sel",   sel,   1);
        chk("empty_count", count, 0);

        // 4. simultaneous write+read in ONE
        step();
        write1(8'h11);
        wr_valid = 1'b1; wr_data = 8'h22; rd_ready = 1'b1;
        exp_q.push_back(8'h22);
        step();
        wr_valid = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        chk("t4_count",  count,   1);
        chk("t4_bank_b", bank_b,  8'h22);
        chk("t4_sel",    sel,     0);
        chk("t4_mux",    mux_out, 8'h22);

        // 5. FULL: writes ignored
        step();
        write1(8'h33);
        wr_valid = 1'b1; wr_data = 8'hFF;
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        chk("t5_bank_a", bank_a, 8'h33);
        chk("t5_bank_b", bank_b, 8'h22);
        chk("t5_count",  count,  2);
        step();
        rd_ready = 1'b1;
        step();
        wr_valid = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        chk("t5r_count",  count,  1);
        chk("t5r_sel",    sel,    1);
        chk("t5r_bank_a", bank_a, 8'h33);
        chk("t5r_bank_b", bank_b, 8'h22);
        step();
        write1(8'h44);
        @(negedge clk);
        chk("t5f_bank_b", bank_b, 8'h44);
        chk("t5f_count",  count,  2);

        // 6. reset while FULL with handshakes asserted
        step();
        rst = 1'b1; wr_valid = 1'b1; wr_data = 8'h55; rd_ready = 1'b1;
        @(negedge clk);
        chk("t6_wr_ready", wr_ready, 0);
        step();
        wr_valid = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        chk("t6_count",  count,  0);
        chk("t6_sel",    sel,    1);
        chk("t6_bank_a", bank_a, 0);
        chk("t6_bank_b", bank_b, 0);
        exp_q.delete();
        step();
        rst = 1'b0;
        step();

        // Post-reset write pointer restarts at A
        write1(8'h66);
        @(negedge clk);
        chk("post_bank_a", bank_a, 8'h66);
        step();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        @(negedge clk);
        chk("post_count", count, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
